// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer
//   Drives the select code {A,B,C} and enable en of a 3-to-8 active-low
//   decoder. Each unmasked channel is held active for dwell+1 cycles, with
//   BLANK_CYCLES en-low cycles between channels. The select code changes at
//   the start of the gap, so the decoder sees a stable code before en rises.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   start     : one-cycle scan request, accepted only when idle and stop=0
//   stop      : end the scan at the end of the current dwell (latched)
//   single    : 1 = one pass over 0..7, 0 = wrap until stopped (sampled on start)
//   dwell     : active length minus one (sampled on entry to each dwell)
//   skip_mask : bit i = 1 skips channel i (read at every channel selection)
//   A, B, C   : registered select code, A is the MSB
//   en        : registered decoder enable, active high
//   busy      : high while a scan is in progress
//   done      : one-cycle pulse when a scan ends
module scan_select_sequencer #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         skip_mask,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

  state_t             r_state;
  logic [2:0]         r_sel;
  logic               r_en;
  logic               r_busy;
  logic               r_done;
  logic               r_stop;
  logic               r_single;
  logic [DWELL_W-1:0] r_cnt;
  logic [BW-1:0]      r_bcnt;

  logic               w_first_vld;
  logic [2:0]         w_first_ch;
  logic               w_next_vld;
  logic [2:0]         w_next_ch;

  // Lowest unmasked channel, used when a scan is accepted.
  always_comb begin
    w_first_vld = ~&skip_mask;
    w_first_ch  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        w_first_ch = 3'(i);
      end
    end
  end

  // Next unmasked channel above the current one. Offsets are scanned from
  // far to near so the nearest candidate wins. Offset 8 wraps back onto the
  // current channel, which lets a lone unmasked channel be reselected in
  // continuous mode; single mode only accepts candidates that do not wrap.
  always_comb begin
    w_next_vld = 1'b0;
    w_next_ch  = r_sel;
    for (int k = 8; k >= 1; k--) begin
      if (!skip_mask[r_sel + 3'(k)] && (!r_single || (int'(r_sel) + k) <= 7)) begin
        w_next_vld = 1'b1;
        w_next_ch  = r_sel + 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stop   <= 1'b0;
      r_single <= 1'b0;
      r_cnt    <= '0;
      r_bcnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_single <= single;
            if (w_first_vld) begin
              r_state <= S_DWELL;
              r_sel   <= w_first_ch;
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
              r_cnt   <= dwell;
            end else begin
              // Every channel masked: report completion without scanning.
              r_done <= 1'b1;
            end
          end
        end

        S_DWELL: begin
          if (stop) begin
            r_stop <= 1'b1;
          end
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (r_stop || stop || !w_next_vld) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stop  <= 1'b0;
          end else begin
            r_sel <= w_next_ch;
            if (BLANK_CYCLES == 0) begin
              // No gap: stay in DWELL with en held high on the new channel.
              r_cnt <= dwell;
            end else begin
              r_state <= S_BLANK;
              r_en    <= 1'b0;
              r_bcnt  <= BLANK_LOAD;
            end
          end
        end

        S_BLANK: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stop  <= 1'b0;
          end else if (r_bcnt == '0) begin
            r_state <= S_DWELL;
            r_en    <= 1'b1;
            r_cnt   <= dwell;
          end else begin
            r_bcnt <= r_bcnt - BW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A    = r_sel[2];
  assign B    = r_sel[1];
  assign C    = r_sel[0];
  assign en   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_scan_select_sequencer.sv
module tb_scan_select_sequencer;

  localparam int DW = 8;
  localparam int BC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          single;
  logic [DW-1:0] dwell;
  logic [7:0]    skip_mask;
  logic          A, B, C, en, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int model_sel = 0;

  always #5 clk = ~clk;

  scan_select_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .single(single),
    .dwell(dwell), .skip_mask(skip_mask),
    .A(A), .B(B), .C(C), .en(en), .busy(busy), .done(done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Runs one scan from idle; stop is pulsed during cycle stop_at (0 = never).
  task automatic run_scan(input int dw, input logic [7:0] m, input bit sg,
                          input int stop_at, output int done_j, output int n_en,
                          output int first_ch, output int last_ch,
                          output int en_nobusy);
    dwell = DW'(dw); skip_mask = m; single = sg; start = 1'b1; stop = 1'b0;
    done_j = -1; n_en = 0; first_ch = -1; last_ch = -1; en_nobusy = 0;
    for (int j = 1; j <= 300; j++) begin
      step();
      start = 1'b0;
      stop  = (j == stop_at);
      if (en && first_ch < 0) first_ch = int'({A, B, C});
      if (en) n_en++;
      if (en && !busy) en_nobusy++;
      if (done) begin
        done_j  = j;
        last_ch = int'({A, B, C});
        stop    = 1'b0;
        break;
      end
    end
    stop = 1'b0;
  endtask

  typedef struct {
    int         dw;
    logic [7:0] mask;
    bit         sg;
    int         stop_at;
    int         exp_done;
    int         exp_en;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t tbl[11];

  // Reference model: builds the whole expected trace from the channel list,
  // then trims it where the stop request takes effect.
  task automatic rand_scan(input int n);
    int  dw, s, k_len, xs, v, nxt, base, dsel, lim;
    logic [7:0] m;
    bit  sg;
    int  chans[$];
    bit  e_en[$];
    int  e_sel[$];
    int  e_end[$];
    bit  x_en, x_busy, x_done;
    int  x_sel;

    dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0:       m = 8'hFF;
      1:       m = ~(8'h01 << $urandom_range(0, 7));
      default: m = 8'($urandom);
    endcase
    sg = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) if (!m[i]) chans.push_back(i);

    s = 0;
    k_len = 0;
    if (chans.size() > 0) begin
      v = 0;
      while (1) begin
        base = e_en.size();
        for (int d = 0; d <= dw; d++) begin
          e_en.push_back(1'b1); e_sel.push_back(chans[v % chans.size()]); e_end.push_back(base + dw);
        end
        v++;
        if (sg && v == chans.size()) break;
        if (!sg && e_en.size() >= 60) break;
        nxt = chans[v % chans.size()];
        for (int b = 0; b < BC; b++) begin
          e_en.push_back(1'b0); e_sel.push_back(nxt); e_end.push_back(e_en.size() - 1);
        end
      end
      if (sg) begin
        s = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, e_en.size()));
      end else begin
        lim = (e_en.size() < 40) ? e_en.size() : 40;
        s = int'($urandom_range(1, lim));
      end
      if (s == 0) k_len = e_en.size();
      else k_len = e_en[s-1] ? e_end[s-1] + 1 : s;
    end
    dsel = (k_len > 0) ? e_sel[k_len-1] : model_sel;
    xs = (k_len > 0) ? int'($urandom_range(1, k_len)) : 0;

    dwell = DW'(dw); skip_mask = m; single = sg; start = 1'b1; stop = 1'b0;
    for (int j = 1; j <= k_len + 2; j++) begin
      step();
      start = (j == xs);
      stop  = (j == s);
      if (j <= k_len) begin
        x_en = e_en[j-1]; x_sel = e_sel[j-1]; x_busy = 1'b1; x_done = 1'b0;
      end else begin
        x_en = 1'b0; x_sel = dsel; x_busy = 1'b0; x_done = (j == k_len + 1);
      end
      check($sformatf("rand%0d_j%0d_en", n, j), en, x_en);
      check($sformatf("rand%0d_j%0d_sel", n, j), {A, B, C}, x_sel);
      check($sformatf("rand%0d_j%0d_busy", n, j), busy, x_busy);
      check($sformatf("rand%0d_j%0d_done", n, j), done, x_done);
    end
    start = 1'b0; stop = 1'b0;
    model_sel = dsel;
    $display("rand %0d: dwell=%0d mask=%02h single=%0d stop@%0d extra_start@%0d cycles=%0d",
             n, dw, m, sg, s, xs, k_len + 1);
  endtask

  initial begin
    int done_j, n_en, first_ch, last_ch, en_nobusy;

    //            dwell mask  single stop done en first last
    tbl[0]  = '{2, 8'h00, 1'b1, 0,  32, 24, 0,  7};
    tbl[1]  = '{0, 8'hAA, 1'b1, 0,  8,  4,  0,  6};
    tbl[2]  = '{1, 8'h00, 1'b0, 10, 12, 8,  0,  3};
    tbl[3]  = '{1, 8'h00, 1'b0, 25, 27, 18, 0,  0};
    tbl[4]  = '{0, 8'hEF, 1'b0, 5,  6,  3,  4,  4};
    tbl[5]  = '{0, 8'h7E, 1'b0, 5,  6,  3,  0,  0};
    tbl[6]  = '{0, 8'h00, 1'b0, 2,  3,  1,  0,  1};
    tbl[7]  = '{2, 8'h00, 1'b0, 3,  4,  3,  0,  0};
    tbl[8]  = '{3, 8'h7F, 1'b1, 0,  5,  4,  7,  7};
    tbl[9]  = '{0, 8'h80, 1'b1, 0,  14, 7,  0,  6};
    tbl[10] = '{5, 8'hFF, 1'b1, 0,  1,  0,  -1, 6};

    rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0; dwell = '0; skip_mask = '0;
    step();
    step();
    check("reset_en", en, 0);
    check("reset_sel", {A, B, C}, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    $display("reset: en=%0d sel=%0d busy=%0d done=%0d", en, {A, B, C}, busy, done);
    rst = 1'b0;
    step();

    // start and stop together in idle: no scan
    skip_mask = 8'h00; dwell = '0; single = 1'b1; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_en", en, 0);
    check("startstop_busy", busy, 0);
    check("startstop_done", done, 0);
    step();
    check("startstop_busy2", busy, 0);
    check("startstop_done2", done, 0);
    $display("start+stop: busy=%0d done=%0d", busy, done);

    for (int i = 0; i < 11; i++) begin
      run_scan(tbl[i].dw, tbl[i].mask, tbl[i].sg, tbl[i].stop_at,
               done_j, n_en, first_ch, last_ch, en_nobusy);
      check($sformatf("vec%0d_done_cycle", i), done_j, tbl[i].exp_done);
      check($sformatf("vec%0d_en_cycles", i), n_en, tbl[i].exp_en);
      check($sformatf("vec%0d_first_ch", i), first_ch, tbl[i].exp_first);
      check($sformatf("vec%0d_last_ch", i), last_ch, tbl[i].exp_last);
      check($sformatf("vec%0d_en_without_busy", i), en_nobusy, 0);
      step();
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      $display("vec %0d: done@%0d en_cycles=%0d first=%0d last=%0d", i, done_j, n_en, first_ch, last_ch);
    end

    // reset in the middle of channel 5 (dwell 4 + blank 1 per channel)
    dwell = DW'(3); skip_mask = 8'h00; single = 1'b0; start = 1'b1;
    for (int j = 1; j <= 27; j++) begin
      step();
      start = 1'b0;
    end
    check("midrst_pre_en", en, 1);
    check("midrst_pre_sel", {A, B, C}, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_en", en, 0);
    check("midrst_sel", {A, B, C}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    $display("reset mid-dwell: en=%0d sel=%0d busy=%0d done=%0d", en, {A, B, C}, busy, done);
    run_scan(0, 8'h00, 1'b1, 0, done_j, n_en, first_ch, last_ch, en_nobusy);
    check("postrst_first_ch", first_ch, 0);
    check("postrst_done_cycle", done_j, 16);
    check("postrst_last_ch", last_ch, 7);
    step();
    model_sel = 7;
    $display("fresh scan after reset: first=%0d done@%0d", first_ch, done_j);

    for (int n = 0; n < 40; n++) rand_scan(n);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
